// File: rtl/key_evt_pkg.sv
// Shared constants, event type and helpers for the key event encoder slice.
package key_evt_pkg;

    localparam int KEY_NUM       = 16;
    localparam int IDX_W         = 4;
    localparam int EVT_W         = 5;
    localparam int EVT_PRESS_BIT = 4;

    typedef logic [EVT_W-1:0] key_evt_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    function automatic key_evt_t evt_make(input logic press, input logic [IDX_W-1:0] idx);
        return {press, idx};
    endfunction

    function automatic logic evt_press(input key_evt_t evt);
        return evt[EVT_PRESS_BIT];
    endfunction

    function automatic logic [IDX_W-1:0] evt_index(input key_evt_t evt);
        return evt[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
module key_evt_fifo
    import key_evt_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8,
    localparam int PTR_W = clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Push,
    input  logic [WIDTH-1:0] Push_data,
    input  logic             Pop,
    output logic [WIDTH-1:0] Pop_data,
    output logic             Valid,
    output logic [PTR_W:0]   Count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty    = (Count == '0);
        full     = (Count == (PTR_W+1)'(DEPTH));
        do_push  = Push && !full;
        do_pop   = Pop && !empty;
        Valid    = !empty;
        Pop_data = empty ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)
                Count <= Count + (PTR_W+1)'(1);
            else if (!do_push && do_pop)
                Count <= Count - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= Push_data;
    end

endmodule

// File: rtl/key_event_encoder.sv
// Debounces the scanned 4x4 key bitmap and queues press/release events
// for the register/interrupt layer.
module key_event_encoder
    import key_evt_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [KEY_NUM-1:0]          Key,
    input  logic                        Sample_en,
    output logic [KEY_NUM-1:0]          Key_state,
    output logic [EVT_W-1:0]            Evt_data,
    output logic                        Evt_valid,
    input  logic                        Evt_ready,
    output logic [clog2(FIFO_DEPTH):0]  Fifo_count,
    output logic                        Overflow,
    input  logic                        Clr_ovf
);

    localparam int CNT_W  = clog2(DEBOUNCE_CNT);
    localparam int FCNT_W = clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    logic [CNT_W-1:0]   cnt [KEY_NUM];
    logic [KEY_NUM-1:0] toggle;
    logic [KEY_NUM-1:0] pending;
    logic [KEY_NUM-1:0] pending_nxt;
    logic [KEY_NUM-1:0] drain;
    logic [IDX_W-1:0]   sel;
    logic               found;
    logic               fire;
    logic               collapse;
    logic               fifo_full;
    key_evt_t           push_data;

    always_comb begin
        toggle = '0;
        for (int unsigned i = 0; i < KEY_NUM; i++)
            toggle[i] = Sample_en && (Key[i] != Key_state[i]) && (cnt[i] == CNT_LAST);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Key_state <= '0;
            for (int unsigned i = 0; i < KEY_NUM; i++) cnt[i] <= '0;
        end else if (Sample_en) begin
            for (int unsigned i = 0; i < KEY_NUM; i++) begin
                if (Key[i] == Key_state[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    Key_state[i] <= ~Key_state[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Push carries the pre-edge Key_state; a same-cycle toggle re-arms pending.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < KEY_NUM; i++) begin
            if (pending[i] && !found) begin
                sel   = IDX_W'(i);
                found = 1'b1;
            end
        end
        fifo_full = (Fifo_count == FCNT_W'(FIFO_DEPTH));
        fire      = found && !fifo_full;
        drain     = '0;
        if (fire) drain[sel] = 1'b1;
        push_data = evt_make(Key_state[sel], sel);

        pending_nxt = pending;
        collapse    = 1'b0;
        for (int unsigned i = 0; i < KEY_NUM; i++) begin
            if (toggle[i]) begin
                if (pending[i] && !drain[i]) begin
                    pending_nxt[i] = 1'b0;
                    collapse       = 1'b1;
                end else begin
                    pending_nxt[i] = 1'b1;
                end
            end else if (drain[i]) begin
                pending_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pending  <= '0;
            Overflow <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (collapse)
                Overflow <= 1'b1;
            else if (Clr_ovf)
                Overflow <= 1'b0;
        end
    end

    key_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .Push      (fire),
        .Push_data (push_data),
        .Pop       (Evt_ready),
        .Pop_data  (Evt_data),
        .Valid     (Evt_valid),
        .Count     (Fifo_count)
    );

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed bench for key_event_encoder with a per-cycle reference model.
module tb_key_event_encoder;
    import key_evt_pkg::*;

    localparam int DEB   = 16;
    localparam int DEPTH = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] Key = '0;
    logic        Sample_en = 1'b0;
    logic        Evt_ready = 1'b0;
    logic        Clr_ovf = 1'b0;
    logic [15:0] Key_state;
    logic [4:0]  Evt_data;
    logic        Evt_valid;
    logic [3:0]  Fifo_count;
    logic        Overflow;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    key_event_encoder #(
        .DEBOUNCE_CNT (DEB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Key        (Key),
        .Sample_en  (Sample_en),
        .Key_state  (Key_state),
        .Evt_data   (Evt_data),
        .Evt_valid  (Evt_valid),
        .Evt_ready  (Evt_ready),
        .Fifo_count (Fifo_count),
        .Overflow   (Overflow),
        .Clr_ovf    (Clr_ovf)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: run length of differing strobes per key, pending set, event queue.
    int          m_run [16];
    bit   [15:0] m_state;
    bit   [15:0] m_pend;
    bit          m_ovf;
    logic [4:0]  m_q [$];

    always @(posedge CLK or posedge RST) begin
        bit [15:0]  flip;
        int         sel;
        bit         pushed;
        bit         lost;
        logic [4:0] ev;
        if (RST) begin
            m_state = '0;
            m_pend  = '0;
            m_ovf   = 1'b0;
            m_q.delete();
            for (int i = 0; i < 16; i++) m_run[i] = 0;
        end else begin
            sel = -1;
            for (int i = 0; i < 16; i++)
                if (m_pend[i] && sel < 0) sel = i;
            pushed = (sel >= 0) && (m_q.size() < DEPTH);
            ev = '0;
            if (pushed) ev = {m_state[sel], 4'(sel)};
            if (m_q.size() > 0 && Evt_ready) void'(m_q.pop_front());
            if (pushed) m_q.push_back(ev);
            flip = '0;
            if (Sample_en) begin
                for (int i = 0; i < 16; i++) begin
                    if (Key[i] != m_state[i]) begin
                        m_run[i]++;
                        if (m_run[i] == DEB) begin
                            flip[i]  = 1'b1;
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            lost = 1'b0;
            for (int i = 0; i < 16; i++) begin
                if (flip[i]) begin
                    if (m_pend[i] && !(pushed && sel == i)) begin
                        m_pend[i] = 1'b0;
                        lost      = 1'b1;
                    end else begin
                        m_pend[i] = 1'b1;
                    end
                end else if (pushed && sel == i) begin
                    m_pend[i] = 1'b0;
                end
            end
            if (lost) m_ovf = 1'b1;
            else if (Clr_ovf) m_ovf = 1'b0;
            m_state = m_state ^ flip;
        end
    end

    logic [4:0] popped [$];
    int         pop_cyc [$];

    always @(negedge CLK) begin
        cycle++;
        check("key_state", 32'(Key_state), 32'(m_state));
        check("evt_valid", 32'(Evt_valid), 32'(m_q.size() > 0));
        check("fifo_count", 32'(Fifo_count), 32'(m_q.size()));
        check("overflow", 32'(Overflow), 32'(m_ovf));
        if (m_q.size() > 0) check("evt_data", 32'(Evt_data), 32'(m_q[0]));
        if (Evt_valid && Evt_ready && !RST) begin
            popped.push_back(Evt_data);
            pop_cyc.push_back(cycle);
        end
    end

    logic [4:0] exp_q [$];

    task automatic check_log(input string name);
        check({name, "_count"}, 32'(popped.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < popped.size(); i++)
            check(name, 32'(popped[i]), 32'(exp_q[i]));
    endtask

    task automatic clear_log();
        popped.delete();
        pop_cyc.delete();
        exp_q.delete();
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic strobes(input int n);
        repeat (n) begin
            Sample_en = 1'b1;
            step(1);
            Sample_en = 1'b0;
            step(1);
        end
    endtask

    initial begin
        RST = 1'b1;
        repeat (10) begin
            Key       = 16'($urandom);
            Sample_en = 1'($urandom_range(0, 1));
            step(1);
        end
        check("rst_key_state", 32'(Key_state), 32'h0);
        check("rst_evt_valid", 32'(Evt_valid), 32'h0);
        check("rst_fifo_count", 32'(Fifo_count), 32'h0);
        check("rst_overflow", 32'(Overflow), 32'h0);
        check("rst_evt_data", 32'(Evt_data), 32'h0);
        Key = '0;
        Sample_en = 1'b0;
        RST = 1'b0;
        step(3);
        strobes(3);
        check("idle_key_state", 32'(Key_state), 32'h0);
        check("idle_evt_valid", 32'(Evt_valid), 32'h0);
        clear_log();

        Evt_ready = 1'b1;
        Key = 16'h0020;
        strobes(15);
        check("press_15", 32'(Key_state), 32'h0);
        strobes(1);
        check("press_16", 32'(Key_state), 32'h0020);
        step(4);
        exp_q.push_back(5'h15);
        check_log("press_evt");
        clear_log();
        Key = '0;
        strobes(16);
        step(4);
        check("release_state", 32'(Key_state), 32'h0);
        exp_q.push_back(5'h05);
        check_log("release_evt");
        clear_log();

        for (int k = 0; k < 100; k++) begin
            Key    = '0;
            Key[3] = 1'((k / 4) % 2);
            strobes(1);
        end
        Key = '0;
        step(4);
        check("bounce_state", 32'(Key_state), 32'h0);
        check_log("bounce_evt");
        Key = 16'h0008;
        strobes(15);
        check("bounce_cnt_zero", 32'(Key_state), 32'h0);
        strobes(1);
        check("bounce_then_press", 32'(Key_state), 32'h0008);
        Key = '0;
        strobes(16);
        step(4);
        exp_q.push_back(5'h13);
        exp_q.push_back(5'h03);
        check_log("key3_evt");
        clear_log();

        Key = 16'h0204;
        strobes(16);
        step(4);
        exp_q.push_back(5'h12);
        exp_q.push_back(5'h19);
        check_log("simul_evt");
        if (pop_cyc.size() == 2) check("simul_adjacent", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
        else check("simul_pops", 32'(pop_cyc.size()), 32'd2);
        clear_log();
        Key = '0;
        strobes(16);
        step(4);
        exp_q.push_back(5'h02);
        exp_q.push_back(5'h09);
        check_log("simul_rel");
        clear_log();

        Evt_ready = 1'b0;
        Key = 16'h03FF;
        strobes(16);
        step(10);
        check("bp_count", 32'(Fifo_count), 32'd8);
        check("bp_head", 32'(Evt_data), 32'h10);
        check("bp_pending", 32'(dut.pending), 32'h0300);
        Evt_ready = 1'b1;
        step(14);
        for (int i = 0; i < 10; i++) exp_q.push_back(5'(5'h10 + i));
        check_log("bp_evt");
        check("bp_overflow", 32'(Overflow), 32'h0);
        clear_log();
        Key = '0;
        strobes(16);
        step(14);
        for (int i = 0; i < 10; i++) exp_q.push_back(5'(i));
        check_log("bp_rel");
        clear_log();

        Evt_ready = 1'b0;
        Key = 16'h00FF;
        strobes(16);
        step(10);
        check("col_full", 32'(Fifo_count), 32'd8);
        Key = 16'h10FF;
        strobes(16);
        check("col_press", 32'(Key_state), 32'h10FF);
        check("col_no_ovf", 32'(Overflow), 32'h0);
        Key = 16'h00FF;
        strobes(16);
        check("col_ovf", 32'(Overflow), 32'h1);
        check("col_state", 32'(Key_state), 32'h00FF);
        check("col_count", 32'(Fifo_count), 32'd8);
        Clr_ovf = 1'b1;
        step(1);
        Clr_ovf = 1'b0;
        check("clr_ovf", 32'(Overflow), 32'h0);
        Evt_ready = 1'b1;
        step(12);
        for (int i = 0; i < 8; i++) exp_q.push_back(5'(5'h10 + i));
        check_log("col_evt");
        clear_log();

        Evt_ready = 1'b0;
        Key = 16'h00E0;
        strobes(16);
        step(8);
        check("rst5_count", 32'(Fifo_count), 32'd5);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check("rst_mid_count", 32'(Fifo_count), 32'd0);
        check("rst_mid_valid", 32'(Evt_valid), 32'h0);
        check("rst_mid_state", 32'(Key_state), 32'h0);
        step(1);
        RST = 1'b0;
        Key = '0;
        step(3);
        check("post_rst_count", 32'(Fifo_count), 32'd0);
        check("post_rst_ovf", 32'(Overflow), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
